// File: rtl/item_mem.sv
// Item table: per-item cost/stock storage, read responder and dispense bookkeeping.
// A post-reset sweep clears every entry before normal service begins.
module item_mem #(
  parameter int NUM_ITEMS = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cfg_mode,
  input  logic        cfg_wr_en,
  input  logic [9:0]  cfg_addr,
  input  logic [15:0] cfg_cost,
  input  logic [7:0]  cfg_available,
  input  logic        mem_read_en,
  input  logic [9:0]  mem_read_addr,
  output logic [15:0] mem_item_cost,
  output logic [7:0]  mem_item_available,
  output logic        mem_data_valid,
  input  logic        mem_update_en,
  input  logic [9:0]  mem_update_addr,
  output logic        init_done,
  output logic [15:0] total_dispensed,
  output logic        update_err
);

  localparam int AW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam logic [10:0] N_LIM = 11'(NUM_ITEMS);
  localparam logic [9:0]  LAST  = 10'(NUM_ITEMS - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t state_q, state_d;
  logic [9:0] ptr_q;

  logic [15:0] cost_mem  [NUM_ITEMS];
  logic [7:0]  avail_mem [NUM_ITEMS];

  logic [AW-1:0] ra_i, ua_i, ca_i;
  logic in_init, rd_ok, rd_hit;
  logic cfg_ok, upd_act, upd_ok;

  logic          we_cost, we_av;
  logic [AW-1:0] wa;
  logic [15:0]   wcost;
  logic [7:0]    wav;

  assign ra_i = mem_read_addr[AW-1:0];
  assign ua_i = mem_update_addr[AW-1:0];
  assign ca_i = cfg_addr[AW-1:0];

  assign in_init = (state_q == INIT);
  assign rd_ok   = mem_read_en & (in_init | ~cfg_mode);
  assign rd_hit  = ~in_init & ({1'b0, mem_read_addr} < N_LIM);
  assign cfg_ok  = ~in_init & cfg_mode & cfg_wr_en
                 & ({1'b0, cfg_addr} < N_LIM);
  assign upd_act = ~in_init & ~cfg_mode & mem_update_en;
  assign upd_ok  = upd_act
                 & ({1'b0, mem_update_addr} < N_LIM)
                 & (avail_mem[ua_i] != 8'd0);

  // Single write port: sweep, cfg and dispense never coincide.
  always_comb begin
    we_cost = 1'b0;
    we_av   = 1'b0;
    wa      = ptr_q[AW-1:0];
    wcost   = '0;
    wav     = '0;
    unique case (1'b1)
      in_init: begin
        we_cost = 1'b1;
        we_av   = 1'b1;
      end
      cfg_ok: begin
        we_cost = 1'b1;
        we_av   = 1'b1;
        wa      = ca_i;
        wcost   = cfg_cost;
        wav     = cfg_available;
      end
      upd_ok: begin
        we_av = 1'b1;
        wa    = ua_i;
        wav   = avail_mem[ua_i] - 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we_cost) cost_mem[wa] <= wcost;
    if (we_av)   avail_mem[wa] <= wav;
  end

  always_comb begin
    state_d = state_q;
    if (in_init && ptr_q == LAST) state_d = READY;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= INIT;
      ptr_q     <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_done <= (state_d == READY);
      if (in_init) ptr_q <= ptr_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_data_valid     <= 1'b0;
      mem_item_cost      <= '0;
      mem_item_available <= '0;
      update_err         <= 1'b0;
      total_dispensed    <= '0;
    end else begin
      mem_data_valid <= rd_ok;
      if (rd_ok) begin
        mem_item_cost      <= rd_hit ? cost_mem[ra_i] : 16'hFFFF;
        mem_item_available <= rd_hit ? avail_mem[ra_i] : 8'd0;
      end
      update_err <= upd_act & ~upd_ok;
      if (upd_ok && total_dispensed != 16'hFFFF)
        total_dispensed <= total_dispensed + 16'd1;
    end
  end

endmodule

// File: tb/tb_item_mem.sv
// Bench for item_mem: directed table, hand sequences and
// randomized traffic against a behavioural model of the item table.
module tb_item_mem;

  localparam int NI = 8;

  logic        clk, rstn;
  logic        cfg_mode, cfg_wr_en;
  logic [9:0]  cfg_addr;
  logic [15:0] cfg_cost;
  logic [7:0]  cfg_available;
  logic        mem_read_en;
  logic [9:0]  mem_read_addr;
  logic [15:0] mem_item_cost;
  logic [7:0]  mem_item_available;
  logic        mem_data_valid;
  logic        mem_update_en;
  logic [9:0]  mem_update_addr;
  logic        init_done;
  logic [15:0] total_dispensed;
  logic        update_err;

  item_mem #(.NUM_ITEMS(NI)) dut (
    .clk(clk), .rstn(rstn),
    .cfg_mode(cfg_mode), .cfg_wr_en(cfg_wr_en),
    .cfg_addr(cfg_addr), .cfg_cost(cfg_cost),
    .cfg_available(cfg_available),
    .mem_read_en(mem_read_en),
    .mem_read_addr(mem_read_addr),
    .mem_item_cost(mem_item_cost),
    .mem_item_available(mem_item_available),
    .mem_data_valid(mem_data_valid),
    .mem_update_en(mem_update_en),
    .mem_update_addr(mem_update_addr),
    .init_done(init_done),
    .total_dispensed(total_dispensed),
    .update_err(update_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        cm;
    logic        cw;
    logic [9:0]  ca;
    logic [15:0] cc;
    logic [7:0]  cav;
    logic        rd;
    logic [9:0]  ra;
    logic        up;
    logic [9:0]  ua;
  } in_t;

  typedef struct {
    in_t         i;
    logic        v;
    logic [15:0] c;
    logic [7:0]  a;
    logic        e;
    logic [15:0] t;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  // behavioural model of the item table
  int          init_cnt;
  logic [15:0] m_cost [NI];
  logic [7:0]  m_av   [NI];
  int          m_total;
  logic        e_valid, e_err, e_done;
  logic [15:0] e_cost;
  logic [7:0]  e_av;

  function automatic in_t mk(
    input logic cm, input logic cw,
    input int ca, input int cc, input int cav,
    input logic rd, input int ra,
    input logic up, input int ua);
    in_t r;
    r.cm = cm; r.cw = cw;
    r.ca = 10'(ca); r.cc = 16'(cc); r.cav = 8'(cav);
    r.rd = rd; r.ra = 10'(ra);
    r.up = up; r.ua = 10'(ua);
    return r;
  endfunction

  function automatic void model_reset();
    init_cnt = 0;
    m_total  = 0;
    e_valid = 0; e_err = 0; e_done = 0;
    e_cost = 0; e_av = 0;
  endfunction

  function automatic void model_step(input in_t i);
    e_valid = 0;
    e_err   = 0;
    if (init_cnt < NI) begin
      m_cost[init_cnt] = 0;
      m_av[init_cnt]   = 0;
      if (i.rd) begin
        e_valid = 1; e_cost = 16'hFFFF; e_av = 0;
      end
      init_cnt++;
      e_done = (init_cnt >= NI);
    end else if (i.cm) begin
      if (i.cw && int'(i.ca) < NI) begin
        m_cost[i.ca] = i.cc;
        m_av[i.ca]   = i.cav;
      end
    end else begin
      if (i.rd) begin
        e_valid = 1;
        if (int'(i.ra) < NI) begin
          e_cost = m_cost[i.ra]; e_av = m_av[i.ra];
        end else begin
          e_cost = 16'hFFFF; e_av = 0;
        end
      end
      if (i.up) begin
        if (int'(i.ua) < NI && m_av[i.ua] > 0) begin
          m_av[i.ua] = m_av[i.ua] - 8'd1;
          if (m_total < 65535) m_total++;
        end else begin
          e_err = 1;
        end
      end
    end
  endfunction

  task automatic chk_val(input string nm,
                         input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else if (n_tot - n_pass <= 20)
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic chk_model(input string nm);
    logic [42:0] a, x;
    a = {mem_data_valid, mem_item_cost, mem_item_available,
         update_err, init_done, total_dispensed};
    x = {e_valid, e_cost, e_av, e_err, e_done, 16'(m_total)};
    n_tot++;
    if (a == x) n_pass++;
    else if (n_tot - n_pass <= 20)
      $display("FAIL %s: got %h want %h", nm, a, x);
  endtask

  task automatic drive(input in_t i);
    cfg_mode = i.cm; cfg_wr_en = i.cw;
    cfg_addr = i.ca; cfg_cost = i.cc;
    cfg_available = i.cav;
    mem_read_en = i.rd; mem_read_addr = i.ra;
    mem_update_en = i.up; mem_update_addr = i.ua;
  endtask

  task automatic cycle(input in_t i, input string nm);
    drive(i);
    @(posedge clk);
    model_step(i);
    #1;
    chk_model(nm);
  endtask

  in_t idle;
  vec_t tbl [17];

  initial begin
    idle = mk(0,0,0,0,0, 0,0, 0,0);
    drive(idle);
    rstn = 1'b0;
    model_reset();
    #12;
    chk_model("reset_state");
    rstn = 1'b1;

    // INIT: read at cycle 2, cfg write and update ignored
    for (int c = 1; c <= NI; c++) begin
      if (c == 2) begin
        cycle(mk(1,1,0,55,5, 1,3, 1,0), "init_mix");
        chk_val("init_rd_valid", mem_data_valid, 1);
        chk_val("init_rd_cost", mem_item_cost, 16'hFFFF);
        chk_val("init_rd_av", mem_item_available, 0);
        chk_val("init_no_err", update_err, 0);
      end else begin
        cycle(idle, "init_idle");
      end
      chk_val("init_done_edge", init_done, int'(c == NI));
    end
    cycle(mk(0,0,0,0,0, 1,3, 0,0), "rd3");
    chk_val("rd3_valid", mem_data_valid, 1);
    chk_val("rd3_cost", mem_item_cost, 0);
    cycle(idle, "valid_drop");
    chk_val("valid_one_cycle", mem_data_valid, 0);
    cycle(mk(0,0,0,0,0, 1,0, 0,0), "rd0");
    chk_val("init_cfg_dropped", mem_item_available, 0);

    tbl[0]  = '{mk(1,1,5,150,2, 0,0, 0,0), 0,0,0,0,0};
    tbl[1]  = '{mk(0,0,0,0,0, 1,5, 0,0), 1,150,2,0,0};
    tbl[2]  = '{mk(0,0,0,0,0, 0,0, 1,5), 0,0,0,0,1};
    tbl[3]  = '{mk(0,0,0,0,0, 1,5, 0,0), 1,150,1,0,1};
    tbl[4]  = '{mk(0,0,0,0,0, 0,0, 1,5), 0,0,0,0,2};
    tbl[5]  = '{mk(0,0,0,0,0, 1,5, 0,0), 1,150,0,0,2};
    tbl[6]  = '{mk(0,0,0,0,0, 0,0, 1,5), 0,0,0,1,2};
    tbl[7]  = '{mk(0,0,0,0,0, 1,5, 0,0), 1,150,0,0,2};
    tbl[8]  = '{mk(1,1,5,150,2, 1,5, 0,0), 0,0,0,0,2};
    tbl[9]  = '{mk(0,0,0,0,0, 1,5, 1,5), 1,150,2,0,3};
    tbl[10] = '{mk(0,0,0,0,0, 1,5, 0,0), 1,150,1,0,3};
    tbl[11] = '{mk(0,0,0,0,0, 1,9, 0,0), 1,16'hFFFF,0,0,3};
    tbl[12] = '{mk(0,0,0,0,0, 0,0, 1,9), 0,0,0,1,3};
    tbl[13] = '{mk(1,1,9,777,9, 0,0, 1,5), 0,0,0,0,3};
    tbl[14] = '{mk(0,0,0,0,0, 1,1, 0,0), 1,0,0,0,3};
    tbl[15] = '{mk(0,0,0,0,0, 1,5, 0,0), 1,150,1,0,3};
    tbl[16] = '{mk(0,0,0,0,0, 1,3, 1,6), 1,0,0,1,3};
    for (int k = 0; k < 17; k++) begin
      logic [41:0] a, x;
      cycle(tbl[k].i, "tbl_model");
      a = {mem_data_valid, update_err, total_dispensed,
           mem_item_cost, mem_item_available};
      x = {tbl[k].v, tbl[k].e, tbl[k].t,
           tbl[k].v ? tbl[k].c : mem_item_cost,
           tbl[k].v ? tbl[k].a : mem_item_available};
      n_tot++;
      if (a == x) n_pass++;
      else $display("FAIL tbl[%0d]: got %h want %h", k, a, x);
    end

    for (int k = 0; k < 400; k++) begin
      in_t r;
      r.cm  = ($urandom_range(0, 5) == 0);
      r.cw  = 1'($urandom);
      r.ca  = 10'($urandom_range(0, 11));
      r.cc  = 16'($urandom);
      r.cav = 8'($urandom_range(0, 3));
      r.rd  = 1'($urandom);
      r.ra  = 10'($urandom_range(0, 11));
      r.up  = 1'($urandom);
      r.ua  = 10'($urandom_range(0, 11));
      cycle(r, "rand");
    end

    // reset while a read is pending
    cycle(mk(0,0,0,0,0, 1,5, 0,0), "pre_rst_rd");
    drive(mk(0,0,0,0,0, 1,5, 0,0));
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    chk_model("async_rst_outputs");
    @(posedge clk);
    #1;
    chk_model("rst_valid_dropped");
    drive(idle);
    #2;
    rstn = 1'b1;
    for (int c = 1; c <= NI; c++) begin
      cycle(idle, "reinit");
      chk_val("reinit_done", init_done, int'(c == NI));
    end

    // drive total_dispensed into saturation
    for (int k = 0; k < 70000 && m_total < 65535; k++) begin
      if (m_av[2] == 0) cycle(mk(1,1,2,9,255, 0,0, 0,0), "refill");
      else cycle(mk(0,0,0,0,0, 0,0, 1,2), "sat_upd");
    end
    chk_val("sat_reached", total_dispensed, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      if (m_av[2] == 0) cycle(mk(1,1,2,9,255, 0,0, 0,0), "refill");
      cycle(mk(0,0,0,0,0, 0,0, 1,2), "sat_hold");
      chk_val("sat_no_wrap", total_dispensed, 16'hFFFF);
      chk_val("sat_no_err", update_err, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
